// File: rtl/uart_bus_bridge_s.sv
// Bus master that programs the USART after reset, then shuttles bytes between
// two valid/ready streams and the USART DATA register through TX/RX FIFOs.
module uart_bus_bridge_s #(
    parameter int unsigned ADDRESS           = 0,
    parameter int unsigned BUS_ADDR_DATA_LEN = 16,
    parameter int unsigned FIFO_AW           = 4,
    parameter logic [11:0] BAUD_DIV          = 12'd103,
    parameter logic [7:0]  CTRLA_INIT        = 8'h10,
    parameter logic [7:0]  CTRLB_INIT        = 8'h18,
    parameter logic [7:0]  CTRLC_INIT        = 8'h03
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [BUS_ADDR_DATA_LEN-1:0] addr,
    output logic                         rd,
    output logic                         wr,
    output logic [7:0]                   bus_out,
    input  logic [7:0]                   bus_in,
    input  logic                         int_rx_rcv,
    output logic                         cfg_done,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [7:0]                   rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready
);

    localparam int unsigned      DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [2:0]       OFS_DATA   = 3'd0;
    localparam logic [2:0]       OFS_STATUS = 3'd1;
    localparam logic [2:0]       OFS_CTRLA  = 3'd3;
    localparam logic [2:0]       OFS_CTRLB  = 3'd4;
    localparam logic [2:0]       OFS_CTRLC  = 3'd5;
    localparam logic [2:0]       OFS_BAUDA  = 3'd6;
    localparam logic [2:0]       OFS_BAUDB  = 3'd7;
    localparam int unsigned      DREIF_BIT  = 5;
    localparam int unsigned      TX         = 0;
    localparam int unsigned      RX         = 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RX_RD,
        S_TX_POLL,
        S_TX_WRITE,
        S_COOL
    } state_t;

    state_t     state_reg;
    state_t     arb_state;
    logic [2:0] init_idx_reg;
    logic [1:0] cool_cnt_reg;
    logic       arb_now;
    logic [2:0] init_ofs;
    logic [7:0] init_data;

    logic [1:0] fifo_push;
    logic [1:0] fifo_pop;
    logic [1:0] fifo_full;
    logic [1:0] fifo_empty;
    logic [7:0] fifo_din  [2];
    logic [7:0] fifo_head [2];

    function automatic logic [BUS_ADDR_DATA_LEN-1:0] reg_addr(input logic [2:0] ofs);
        return BUS_ADDR_DATA_LEN'(ADDRESS) + BUS_ADDR_DATA_LEN'(ofs);
    endfunction

    // Index 0 is the TX stream (client -> USART), index 1 the RX stream.
    assign fifo_din[TX]  = tx_data;
    assign fifo_din[RX]  = bus_in;
    assign fifo_push[TX] = tx_valid & ~fifo_full[TX];
    assign fifo_pop[TX]  = (state_reg == S_TX_WRITE);
    assign fifo_push[RX] = (state_reg == S_RX_RD);
    assign fifo_pop[RX]  = ~fifo_empty[RX] & rx_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]         mem [DEPTH];
            logic [FIFO_AW-1:0] wr_ptr_reg;
            logic [FIFO_AW-1:0] rd_ptr_reg;
            logic [FIFO_AW:0]   cnt_reg;

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem[wr_ptr_reg] <= fifo_din[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    cnt_reg <= cnt_reg + (FIFO_AW + 1)'(fifo_push[gi])
                                       - (FIFO_AW + 1)'(fifo_pop[gi]);
                end
            end

            assign fifo_head[gi]  = mem[rd_ptr_reg];
            assign fifo_full[gi]  = (cnt_reg == FULL_CNT);
            assign fifo_empty[gi] = (cnt_reg == '0);
        end
    endgenerate

    assign tx_ready = ~fifo_full[TX];
    assign rx_valid = ~fifo_empty[RX];
    assign rx_data  = fifo_head[RX];

    always_comb begin
        init_ofs  = OFS_CTRLB;
        init_data = CTRLB_INIT;
        case (init_idx_reg)
            3'd0: begin init_ofs = OFS_BAUDB; init_data = {4'h0, BAUD_DIV[11:8]}; end
            3'd1: begin init_ofs = OFS_BAUDA; init_data = BAUD_DIV[7:0]; end
            3'd2: begin init_ofs = OFS_CTRLC; init_data = CTRLC_INIT; end
            3'd3: begin init_ofs = OFS_CTRLA; init_data = CTRLA_INIT; end
            default: ;
        endcase
    end

    // RX wins arbitration; a full RX FIFO leaves the byte parked in the USART.
    always_comb begin
        arb_state = S_IDLE;
        if (int_rx_rcv && !fifo_full[RX]) begin
            arb_state = S_RX_RD;
        end else if (!fifo_empty[TX]) begin
            arb_state = S_TX_POLL;
        end
    end

    // The last cool-down cycle doubles as the arbitration slot for throughput.
    assign arb_now = (state_reg == S_IDLE) || (state_reg == S_COOL && cool_cnt_reg == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_INIT;
            init_idx_reg <= '0;
            cool_cnt_reg <= '0;
            addr         <= '0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            bus_out      <= '0;
            cfg_done     <= 1'b0;
        end else begin
            rd   <= 1'b0;
            wr   <= 1'b0;
            addr <= '0;
            case (state_reg)
                S_INIT: begin
                    wr           <= 1'b1;
                    addr         <= reg_addr(init_ofs);
                    bus_out      <= init_data;
                    init_idx_reg <= init_idx_reg + 3'd1;
                    if (init_idx_reg == 3'd4) state_reg <= S_IDLE;
                end
                S_IDLE: cfg_done <= 1'b1;
                S_RX_RD: begin
                    state_reg    <= S_COOL;
                    cool_cnt_reg <= 2'd1;
                end
                S_TX_POLL: begin
                    if (bus_in[DREIF_BIT]) begin
                        state_reg <= S_TX_WRITE;
                        wr        <= 1'b1;
                        addr      <= reg_addr(OFS_DATA);
                        bus_out   <= fifo_head[TX];
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_TX_WRITE: begin
                    state_reg    <= S_COOL;
                    cool_cnt_reg <= 2'd2;
                end
                S_COOL:  cool_cnt_reg <= cool_cnt_reg - 2'd1;
                default: state_reg <= S_IDLE;
            endcase
            if (arb_now) begin
                state_reg <= arb_state;
                if (arb_state == S_RX_RD) begin
                    rd   <= 1'b1;
                    addr <= reg_addr(OFS_DATA);
                end else if (arb_state == S_TX_POLL) begin
                    rd   <= 1'b1;
                    addr <= reg_addr(OFS_STATUS);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge_s.sv
// Directed bench for uart_bus_bridge_s with a small USART register model
// answering DATA/STATUS reads and raising int_rx_rcv for queued bytes.
module tb_uart_bus_bridge_s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  bus_out;
    logic [7:0]  bus_in;
    logic        int_rx_rcv;
    logic        cfg_done;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    bit         dreif = 1'b0;
    int         added = 0;
    int         consumed = 0;
    logic [7:0] rx_src [64];
    int         cyc = 0;
    int         n_wr = 0;
    int         n_poll = 0;
    int         n_rxrd = 0;
    int         overlap = 0;
    logic [7:0] tx_log [$];
    int         rx_cyc_q [$];

    uart_bus_bridge_s dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .rd         (rd),
        .wr         (wr),
        .bus_out    (bus_out),
        .bus_in     (bus_in),
        .int_rx_rcv (int_rx_rcv),
        .cfg_done   (cfg_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    assign int_rx_rcv = (added > consumed);

    always_comb begin
        bus_in = 8'h00;
        if (rd) begin
            if (addr == 16'd0)      bus_in = rx_src[consumed[5:0]];
            else if (addr == 16'd1) bus_in = {2'b00, dreif, 5'b00000};
        end
    end

    // USART side: log strobes of the cycle ending at this edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (rd && wr) overlap = overlap + 1;
            if (wr && addr == 16'd0) begin
                tx_log.push_back(bus_out);
                n_wr = n_wr + 1;
                $display("[%0d] bus write DATA=%02h", cyc, bus_out);
            end
            if (rd && addr == 16'd1) n_poll = n_poll + 1;
            if (rd && addr == 16'd0) begin
                n_rxrd = n_rxrd + 1;
                rx_cyc_q.push_back(cyc);
                $display("[%0d] bus read DATA=%02h", cyc, bus_in);
                if (added > consumed) consumed <= consumed + 1;
            end
        end
    end

    // Called at a negedge; returns at a negedge with tx_valid low.
    task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] exp_a [5];
        logic [7:0]  exp_d [5];
        exp_a = '{16'h7, 16'h6, 16'h5, 16'h3, 16'h4};
        exp_d = '{8'h00, 8'h67, 8'h03, 8'h10, 8'h18};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (addr !== 16'd0 || rd !== 1'b0 || wr !== 1'b0 || bus_out !== 8'h00) begin
            bad++; $display("FAIL reset_bus addr=%h rd=%b wr=%b data=%h want 0/0/0/00", addr, rd, wr, bus_out); end
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL reset_cfg_done got=%b want=0", cfg_done); end
        total++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
            bad++; $display("FAIL reset_fifo rx_valid=%b tx_ready=%b want 0/1", rx_valid, tx_ready); end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (wr !== 1'b1 || rd !== 1'b0 || addr !== exp_a[k] || bus_out !== exp_d[k] || cfg_done !== 1'b0) begin
                bad++; $display("FAIL init_write%0d wr=%b rd=%b addr=%h data=%h cfg=%b want wr=1 addr=%h data=%h cfg=0",
                                k, wr, rd, addr, bus_out, cfg_done, exp_a[k], exp_d[k]); end
        end
        @(negedge clk);
        total++; if (cfg_done !== 1'b1 || wr !== 1'b0) begin
            bad++; $display("FAIL init_done cfg=%b wr=%b want 1/0", cfg_done, wr); end
    endtask

    task automatic test_tx_single;
        int base_poll, base_wr;
        bit ok, seen;
        dreif = 1'b1;
        @(negedge clk);
        base_poll = n_poll;
        base_wr   = n_wr;
        push_byte(8'h55, 10, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL tx_single_accept got=%b want=1", ok); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd) begin seen = 1'b1; break; end
        end
        total++; if (!seen || addr !== 16'd1 || wr !== 1'b0) begin
            bad++; $display("FAIL tx_poll seen=%b addr=%h wr=%b want 1/0001/0", seen, addr, wr); end
        @(negedge clk);
        total++; if (wr !== 1'b1 || rd !== 1'b0 || addr !== 16'd0 || bus_out !== 8'h55 || tx_ready !== 1'b1) begin
            bad++; $display("FAIL tx_write wr=%b rd=%b addr=%h data=%h rdy=%b want 1/0/0000/55/1", wr, rd, addr, bus_out, tx_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (wr !== 1'b0 || rd !== 1'b0 || addr !== 16'd0) begin
                bad++; $display("FAIL tx_cool%0d wr=%b rd=%b addr=%h want 0/0/0000", i, wr, rd, addr); end
        end
        @(negedge clk);
        total++; if (n_poll - base_poll != 1 || n_wr - base_wr != 1) begin
            bad++; $display("FAIL tx_single_counts polls=%0d writes=%0d want 1/1", n_poll - base_poll, n_wr - base_wr); end
    endtask

    task automatic test_tx_backpressure;
        int base_poll, base_wr, log_start, n_ok;
        bit ok, done;
        dreif     = 1'b0;
        base_wr   = n_wr;
        log_start = tx_log.size();
        n_ok      = 0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h80 + 8'(i), 5, ok);
            if (ok) n_ok++;
        end
        total++; if (n_ok != 16) begin bad++; $display("FAIL bp_accept16 got=%0d want=16", n_ok); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL bp_tx_ready got=%b want=0", tx_ready); end
        base_poll = n_poll;
        push_byte(8'h90, 50, ok);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL bp_17th_blocked got=%b want=0", ok); end
        total++; if (n_wr != base_wr) begin bad++; $display("FAIL bp_no_write got=%0d want=0", n_wr - base_wr); end
        total++; if (n_poll - base_poll < 10) begin bad++; $display("FAIL bp_polling got=%0d want>=10", n_poll - base_poll); end
        dreif = 1'b1;
        n_ok  = 0;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h90 + 8'(i), 40, ok);
            if (ok) n_ok++;
        end
        total++; if (n_ok != 4) begin bad++; $display("FAIL bp_accept_rest got=%0d want=4", n_ok); end
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_log.size() - log_start >= 20) begin done = 1'b1; break; end
        end
        total++; if (!done) begin bad++; $display("FAIL bp_drain_timeout got=%0d want=20", tx_log.size() - log_start); end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 16) ? 8'h80 + 8'(i) : 8'h90 + 8'(i - 16);
            total++; if (log_start + i >= tx_log.size() || tx_log[log_start + i] !== exp_b) begin
                bad++; $display("FAIL bp_order%0d got=%h want=%h", i,
                                (log_start + i < tx_log.size()) ? tx_log[log_start + i] : 8'hxx, exp_b); end
        end
    endtask

    task automatic test_rx_single;
        int base, qs;
        bit seen, done;
        rx_ready = 1'b0;
        @(negedge clk);
        base = n_rxrd;
        rx_src[added[5:0]] = 8'hA5;
        added++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd) begin seen = 1'b1; break; end
        end
        total++; if (!seen || addr !== 16'd0 || wr !== 1'b0 || rx_valid !== 1'b0) begin
            bad++; $display("FAIL rx_read seen=%b addr=%h wr=%b rxv=%b want 1/0000/0/0", seen, addr, wr, rx_valid); end
        @(negedge clk);
        total++; if (rd !== 1'b0 || rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            bad++; $display("FAIL rx_data rd=%b rxv=%b data=%h want 0/1/a5", rd, rx_valid, rx_data); end
        @(negedge clk);
        total++; if (rd !== 1'b0 || n_rxrd - base != 1) begin
            bad++; $display("FAIL rx_single_count rd=%b reads=%0d want 0/1", rd, n_rxrd - base); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_pop got=%b want=0", rx_valid); end

        qs = rx_cyc_q.size();
        rx_src[added[5:0]] = 8'h3C; added++;
        rx_src[added[5:0]] = 8'hC3; added++;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rx_cyc_q.size() >= qs + 2) begin done = 1'b1; break; end
        end
        total++; if (!done || rx_cyc_q[qs + 1] - rx_cyc_q[qs] != 2) begin
            bad++; $display("FAIL rx_b2b_gap done=%b gap=%0d want 2", done,
                            done ? rx_cyc_q[qs + 1] - rx_cyc_q[qs] : -1); end
        @(negedge clk);
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL rx_b2b_first got=%h want=3c", rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            bad++; $display("FAIL rx_b2b_second rxv=%b data=%h want 1/c3", rx_valid, rx_data); end
        @(negedge clk);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_b2b_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_rx_full;
        int base;
        bit done;
        rx_ready = 1'b0;
        base = n_rxrd;
        for (int k = 0; k < 17; k++) begin
            rx_src[added[5:0]] = 8'h40 + 8'(k);
            added++;
        end
        repeat (80) @(negedge clk);
        total++; if (n_rxrd - base != 16) begin bad++; $display("FAIL rx_full_reads got=%0d want=16", n_rxrd - base); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h40) begin
            bad++; $display("FAIL rx_full_head rxv=%b data=%h want 1/40", rx_valid, rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (n_rxrd - base == 17) begin done = 1'b1; break; end
        end
        total++; if (!done) begin bad++; $display("FAIL rx_full_17th got=%0d want=17", n_rxrd - base); end
        rx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            total++; if (rx_valid !== 1'b1 || rx_data !== 8'h40 + 8'(k)) begin
                bad++; $display("FAIL rx_full_drain%0d rxv=%b data=%h want 1/%h", k, rx_valid, rx_data, 8'h40 + 8'(k)); end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_full_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_reset_priority;
        logic [15:0] exp_a [5];
        logic [7:0]  exp_d [5];
        int base_wr;
        bit ok, seen;
        exp_a = '{16'h7, 16'h6, 16'h5, 16'h3, 16'h4};
        exp_d = '{8'h00, 8'h67, 8'h03, 8'h10, 8'h18};
        rx_ready = 1'b0;
        dreif    = 1'b1;
        rx_src[added[5:0]] = 8'hE1;
        added++;
        repeat (4) @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rp_pre_rx got=%b want=1", rx_valid); end
        push_byte(8'h77, 10, ok);
        push_byte(8'h78, 10, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!seen || bus_out !== 8'h77) begin bad++; $display("FAIL rp_pre_write seen=%b data=%h want 1/77", seen, bus_out); end
        rst = 1'b1;
        #1;
        total++; if (wr !== 1'b0 || rd !== 1'b0 || addr !== 16'd0 || cfg_done !== 1'b0) begin
            bad++; $display("FAIL rp_async wr=%b rd=%b addr=%h cfg=%b want 0/0/0000/0", wr, rd, addr, cfg_done); end
        total++; if (rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
            bad++; $display("FAIL rp_fifos rxv=%b rdy=%b want 0/1", rx_valid, tx_ready); end
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        base_wr  = n_wr;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        rx_src[added[5:0]] = 8'h5A;
        added++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            total++; if (wr !== 1'b1 || addr !== exp_a[k] || bus_out !== exp_d[k]) begin
                bad++; $display("FAIL rp_init%0d wr=%b addr=%h data=%h want 1/%h/%h", k, wr, addr, bus_out, exp_a[k], exp_d[k]); end
        end
        @(negedge clk);
        total++; if (cfg_done !== 1'b1 || rd !== 1'b1 || addr !== 16'd0) begin
            bad++; $display("FAIL rp_rx_first cfg=%b rd=%b addr=%h want 1/1/0000", cfg_done, rd, addr); end
        @(negedge clk);
        total++; if (rd !== 1'b0 || wr !== 1'b0) begin bad++; $display("FAIL rp_cool rd=%b wr=%b want 0/0", rd, wr); end
        @(negedge clk);
        total++; if (rd !== 1'b1 || addr !== 16'd1) begin bad++; $display("FAIL rp_poll rd=%b addr=%h want 1/0001", rd, addr); end
        @(negedge clk);
        total++; if (wr !== 1'b1 || bus_out !== 8'h99) begin bad++; $display("FAIL rp_write wr=%b data=%h want 1/99", wr, bus_out); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            bad++; $display("FAIL rp_rx_head rxv=%b data=%h want 1/5a", rx_valid, rx_data); end
        repeat (10) @(negedge clk);
        total++; if (n_wr - base_wr != 1) begin bad++; $display("FAIL rp_tx_flushed writes=%0d want 1", n_wr - base_wr); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rp_rx_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_protocol;
        total++; if (overlap != 0) begin bad++; $display("FAIL rd_wr_overlap got=%0d want=0", overlap); end
        total++; if (consumed != added) begin bad++; $display("FAIL rx_all_served got=%0d want=%0d", consumed, added); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_backpressure();
        test_rx_single();
        test_rx_full();
        test_reset_priority();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
